// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: substitutes BYTES_PER_CYCLE state bytes per cycle in place,
// with valid/ready handshakes on both sides and a synchronous abort.
module inv_sub_bytes_seq #(
   parameter int unsigned BYTES_PER_CYCLE = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic         abort,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   localparam int unsigned NumGroups = 16 / BYTES_PER_CYCLE;
   localparam logic [3:0]  LastGroup = 4'(NumGroups - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e        r_state;
   state_e        w_state_next;
   logic [3:0]    r_cnt;
   logic [127:0]  r_work;
   logic [127:0]  w_work_sub;
   logic          w_accept;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8); it also maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] y);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) begin
         b[i] = y[(i + 2) % 8] ^ y[(i + 5) % 8] ^ y[(i + 7) % 8];
      end
      return gf_inv(b ^ 8'h05);
   endfunction

   assign w_accept = (r_state == StIdle) && in_valid && !abort;

   // Only the group selected by the counter is replaced; other bytes pass through.
   always_comb begin
      w_work_sub = r_work;
      for (int j = 0; j < int'(BYTES_PER_CYCLE); j++) begin
         w_work_sub[(int'(r_cnt) * int'(BYTES_PER_CYCLE) + j) * 8 +: 8] =
            inv_sbox(r_work[(int'(r_cnt) * int'(BYTES_PER_CYCLE) + j) * 8 +: 8]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (abort) begin
         w_state_next = StIdle;
      end else begin
         unique case (r_state)
            StIdle:  if (in_valid) w_state_next = StRun;
            StRun:   if (r_cnt == LastGroup) w_state_next = StDone;
            StDone:  if (out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
         endcase
      end
   end

   always_comb begin
      in_ready  = (r_state == StIdle);
      out_valid = (r_state == StDone);
      busy      = (r_state != StIdle);
      out_state = r_work;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_work <= 128'h0;
         r_cnt  <= 4'd0;
      end else if (w_accept) begin
         r_work <= in_state;
         r_cnt  <= 4'd0;
      end else if ((r_state == StRun) && !abort) begin
         r_work <= w_work_sub;
         r_cnt  <= r_cnt + 4'd1;
      end
   end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq at B = 4, 1 and 16; a timestamp-based transaction model
// built from a forward S-box derived by GF(2^8) search is checked every cycle.
module tb_inv_sub_bytes_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_a       [3];
   logic         in_valid_a  [3];
   logic         abort_a     [3];
   logic         out_ready_a [3];
   logic [127:0] in_state_a  [3];
   logic [127:0] out_state_a [3];
   logic         in_ready_a  [3];
   logic         out_valid_a [3];
   logic         busy_a      [3];

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_dut
         inv_sub_bytes_seq #(
            .BYTES_PER_CYCLE((g == 0) ? 4 : ((g == 1) ? 1 : 16))
         ) u_dut (
            .clk      (clk),
            .rst      (rst_a[g]),
            .in_valid (in_valid_a[g]),
            .in_ready (in_ready_a[g]),
            .in_state (in_state_a[g]),
            .abort    (abort_a[g]),
            .out_valid(out_valid_a[g]),
            .out_ready(out_ready_a[g]),
            .out_state(out_state_a[g]),
            .busy     (busy_a[g])
         );
      end
   endgenerate

   int           total = 0;
   int           bad   = 0;
   bit           chk_en = 1'b0;
   int           cyc = 0;
   logic [7:0]   fwd  [256];
   logic [7:0]   invt [256];
   bit           m_pend [3];
   int           m_acc  [3];
   logic [127:0] m_res  [3];

   // Number of RUN cycles per instance.
   function automatic int ngof(input int d);
      return (d == 0) ? 4 : ((d == 1) ? 16 : 1);
   endfunction

   function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      logic [15:0] t;
      t = {x, x} << n;
      return t[15:8];
   endfunction

   function automatic logic [127:0] inv_state(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = invt[s[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] fwd_state(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = fwd[s[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic timeout_fail(input string nm);
      total++;
      bad++;
      $display("FAIL %s: got no event within bound, want event", nm);
   endtask

   // Transaction model: a state accepted at edge A is done from edge A + NG until handed off.
   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (rst_a[d] || abort_a[d]) begin
            m_pend[d] <= 1'b0;
         end else if (!m_pend[d] && in_valid_a[d]) begin
            m_pend[d] <= 1'b1;
            m_acc[d]  <= cyc + 1;
            m_res[d]  <= inv_state(in_state_a[d]);
         end else if (m_pend[d] && (cyc >= m_acc[d] + ngof(d)) && out_ready_a[d]) begin
            m_pend[d] <= 1'b0;
         end
      end
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 3; d++) begin
            chk($sformatf("ctl%0d", d), {125'd0, in_ready_a[d], out_valid_a[d], busy_a[d]},
                {125'd0, !m_pend[d], m_pend[d] && (cyc >= m_acc[d] + ngof(d)), m_pend[d]});
            if (m_pend[d] && (cyc >= m_acc[d] + ngof(d)))
               chk($sformatf("out_state%0d", d), out_state_a[d], m_res[d]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Waits for in_ready, hands over s, then waits for out_valid and checks the latency.
   task automatic accept_wait(input int d, input logic [127:0] s, output bit ok);
      int n;
      ok = 1'b0;
      n = 0;
      while (!in_ready_a[d] && n < 200) begin
         tick();
         n++;
      end
      if (!in_ready_a[d]) begin
         timeout_fail("in_ready");
         return;
      end
      in_valid_a[d] = 1'b1;
      in_state_a[d] = s;
      tick();
      in_valid_a[d] = 1'b0;
      in_state_a[d] = rnd128();
      n = 1;
      while (!out_valid_a[d] && n < 40) begin
         tick();
         n++;
      end
      if (!out_valid_a[d]) begin
         timeout_fail("out_valid");
         return;
      end
      chk($sformatf("latency%0d", d), 128'(n), 128'(ngof(d) + 1));
      ok = 1'b1;
   endtask

   task automatic run_one(input int d, input logic [127:0] s, input int stall,
                          output logic [127:0] got);
      bit ok;
      logic [127:0] first;
      accept_wait(d, s, ok);
      got = 'x;
      if (!ok) return;
      first = out_state_a[d];
      repeat (stall) begin
         in_valid_a[d] = 1'b1;
         in_state_a[d] = rnd128();
         tick();
      end
      in_valid_a[d] = 1'b0;
      if (stall > 0) begin
         chk("hold_state", out_state_a[d], first);
         chk("hold_ctl", {125'd0, in_ready_a[d], out_valid_a[d], busy_a[d]}, 128'b011);
      end
      got = out_state_a[d];
      out_ready_a[d] = 1'b1;
      tick();
      out_ready_a[d] = 1'b0;
   endtask

   initial begin
      logic [127:0] got;
      logic [127:0] s;
      logic [7:0]   inv;
      bit           ok;

      for (int d = 0; d < 3; d++) begin
         rst_a[d]       = 1'b1;
         in_valid_a[d]  = 1'b0;
         abort_a[d]     = 1'b0;
         out_ready_a[d] = 1'b0;
         in_state_a[d]  = 128'h0;
      end

      // Forward S-box from brute-force GF inverse plus affine map, then inverted.
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         fwd[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
      for (int x = 0; x < 256; x++) invt[fwd[x]] = 8'(x);

      chk("pin_fwd00", 128'(fwd[8'h00]), 128'h63);
      chk("pin_fwd53", 128'(fwd[8'h53]), 128'hED);
      chk("pin_inv63", 128'(invt[8'h63]), 128'h00);
      chk("pin_inv7c", 128'(invt[8'h7C]), 128'h01);
      chk("pin_inv16", 128'(invt[8'h16]), 128'hFF);
      chk("pin_inved", 128'(invt[8'hED]), 128'h53);
      chk("pin_inv00", 128'(invt[8'h00]), 128'h52);
      chk("pin_inv52", 128'(invt[8'h52]), 128'h48);

      tick();
      tick();
      chk_en = 1'b1;
      tick();
      for (int d = 0; d < 3; d++) rst_a[d] = 1'b0;
      for (int d = 0; d < 3; d++) begin
         chk("rst_ctl", {125'd0, in_ready_a[d], out_valid_a[d], busy_a[d]}, 128'b100);
         chk("rst_work", out_state_a[d], 128'h0);
      end

      run_one(0, {16{8'h63}}, 0, got);
      chk("all63", got, 128'h0);
      run_one(0, 128'h76ABD7FE2B670130C56F6BF27B777C63, 0, got);
      chk("seq00_0f", got, 128'h0F0E0D0C0B0A09080706050403020100);

      for (int j = 0; j < 16; j++) begin
         for (int i = 0; i < 16; i++) s[8*i +: 8] = 8'(16 * j + i);
         run_one(0, s, 0, got);
         chk("exhaustive", got, inv_state(s));
         chk("identity", fwd_state(got), s);
      end

      s = rnd128();
      run_one(0, s, 10, got);
      chk("backpressure", got, inv_state(s));

      // Abort during the second RUN cycle.
      in_valid_a[0] = 1'b1;
      in_state_a[0] = rnd128();
      tick();
      in_valid_a[0] = 1'b0;
      tick();
      abort_a[0] = 1'b1;
      tick();
      abort_a[0] = 1'b0;
      chk("abort_run", {125'd0, in_ready_a[0], out_valid_a[0], busy_a[0]}, 128'b100);
      repeat (8) tick();
      run_one(0, {16{8'h52}}, 0, got);
      chk("after_abort", got, {16{8'h48}});

      // Abort beats a simultaneous input handshake.
      in_valid_a[0] = 1'b1;
      abort_a[0]    = 1'b1;
      tick();
      in_valid_a[0] = 1'b0;
      abort_a[0]    = 1'b0;
      chk("abort_in", {125'd0, in_ready_a[0], out_valid_a[0], busy_a[0]}, 128'b100);

      // Reset in DONE with out_ready high, on every width.
      for (int d = 0; d < 3; d++) begin
         accept_wait(d, rnd128(), ok);
         out_ready_a[d] = 1'b1;
         rst_a[d]       = 1'b1;
         tick();
         rst_a[d]       = 1'b0;
         out_ready_a[d] = 1'b0;
         chk("rst_done_ctl", {125'd0, in_ready_a[d], out_valid_a[d], busy_a[d]}, 128'b100);
         chk("rst_done_work", out_state_a[d], 128'h0);
      end

      // Reset mid-RUN at B = 1.
      in_valid_a[1] = 1'b1;
      in_state_a[1] = rnd128();
      tick();
      in_valid_a[1] = 1'b0;
      repeat (3) tick();
      rst_a[1] = 1'b1;
      tick();
      rst_a[1] = 1'b0;
      chk("rst_run_work", out_state_a[1], 128'h0);
      repeat (20) tick();

      for (int d = 0; d < 3; d++) begin
         for (int t = 0; t < 15; t++) begin
            s = rnd128();
            repeat ($urandom_range(0, 2)) tick();
            run_one(d, s, int'($urandom_range(0, 3)), got);
            chk("random", got, inv_state(s));
         end
      end

      repeat (3) tick();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
